// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/response bundle between the core stages and pipe_ctrl
interface pipe_ctrl_if;
   logic        stallreq_id;
   logic        mc_start;
   logic        excp_req;
   logic [31:0] excp_vec;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_done;
   logic        busy;
   logic [31:0] stall_cycles;

   modport master (
      output stallreq_id, mc_start, excp_req, excp_vec,
      input  stall, flush, new_pc, mc_done, busy, stall_cycles
   );

   modport slave (
      input  stallreq_id, mc_start, excp_req, excp_vec,
      output stall, flush, new_pc, mc_done, busy, stall_cycles
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - per-stage stall/flush sequencing for the five-stage core
module pipe_ctrl #(
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 4
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);
   localparam logic [5:0]       LP_STALL_MC  = 6'b001111;
   localparam logic [5:0]       LP_STALL_LU  = 6'b000111;
   localparam logic [CNT_W-1:0] LP_CNT_INIT  = CNT_W'(MC_LAT - 2);

   typedef enum logic {S_IDLE, S_MC} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_stall_cycles;

   state_t           w_next_state;
   logic [CNT_W-1:0] w_next_cnt;
   logic [5:0]       w_stall;
   logic             w_flush;
   logic [31:0]      w_new_pc;
   logic             w_mc_done;

   // Outputs are forced quiet while reset is held, whatever the inputs do.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_stall      = 6'b0;
      w_flush      = 1'b0;
      w_new_pc     = 32'h0;
      w_mc_done    = 1'b0;
      if (!rst) begin
         w_next_state = S_IDLE;
         w_next_cnt   = '0;
      end else if (bus.excp_req) begin
         w_flush      = 1'b1;
         w_new_pc     = bus.excp_vec;
         w_next_state = S_IDLE;
         w_next_cnt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.mc_start) begin
                  w_stall      = LP_STALL_MC;
                  w_next_cnt   = LP_CNT_INIT;
                  w_next_state = S_MC;
               end else if (bus.stallreq_id) begin
                  w_stall = LP_STALL_LU;
               end
            end
            S_MC: begin
               if (r_cnt != '0) begin
                  w_stall    = LP_STALL_MC;
                  w_next_cnt = r_cnt - 1'b1;
               end else begin
                  // Final EX cycle: mc_start still high here belongs to this op.
                  w_mc_done    = 1'b1;
                  w_stall      = bus.stallreq_id ? LP_STALL_LU : 6'b0;
                  w_next_state = S_IDLE;
               end
            end
            default: begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_stall_cycles <= 32'h0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if ((w_stall != 6'b0) && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign bus.stall        = w_stall;
   assign bus.flush        = w_flush;
   assign bus.new_pc       = w_new_pc;
   assign bus.mc_done      = w_mc_done;
   assign bus.busy         = (r_state == S_MC);
   assign bus.stall_cycles = r_stall_cycles;
endmodule
